// File: rtl/sort4_sequencer_pkg.sv
// Shared types for the 4-word sort sequencer: word width, element count,
// index/mask types and the sequencer state encoding.
package sort_pkg;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    typedef logic [1:0] idx_t;
    typedef logic [3:0] mask_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EMIT   = 2'd2
    } state_t;

    function automatic logic [2:0] popcount4(input mask_t m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

endpackage

// File: rtl/sort4_sequencer_if.sv
// Batch-in / sorted-stream-out bundle for sort4_sequencer.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface sort4_if #(
    parameter int W = 16
);
    import sort_pkg::*;

    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_c;
    logic [W-1:0] in_d;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    idx_t         out_idx;
    logic         out_last;
    logic         busy;

    modport slave (
        input  clr, in_valid, in_a, in_b, in_c, in_d, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output clr, in_valid, in_a, in_b, in_c, in_d, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/sort4_sequencer_sel4_extreme.sv
// Combinational masked argmax over four words; argmin when SORT4_ASCEND_EN
// is defined. Lowest index wins ties; masked-out entries never win.
module sel4_extreme
    import sort_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  mask_t        mask,
    output logic [W-1:0] val,
    output idx_t         idx
);

    logic [W-1:0] words [N];
    logic         found;

    assign words[0] = a;
    assign words[1] = b;
    assign words[2] = c;
    assign words[3] = d;

    function automatic logic beats(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SORT4_ASCEND_EN
        return x < y;
`else
        return x > y;
`endif
    endfunction

    // Strict compare keeps the earlier index on equal values.
    always_comb begin
        val   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (!found || beats(words[i], val))) begin
                val   = words[i];
                idx   = idx_t'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sort4_sequencer.sv
// Serial 4-word sorter: latches a batch, then repeatedly picks the extreme
// remaining word and streams it out. SORT4_ASCEND_EN flips the order.
//
// state  | meaning
// IDLE   | waiting for a batch; in_ready high unless clr
// SELECT | one cycle: register winner of the remaining set
// EMIT   | hold output until consumer takes it, then retire that element
module sort4_sequencer
    import sort_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    sort4_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SELECT = SELECT;
    localparam logic [1:0] ST_EMIT   = EMIT;

    logic [1:0]   state;
    logic [W-1:0] elem [N];
    mask_t        mask;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    idx_t         out_idx_q;
    logic         out_last_q;
    logic [W-1:0] sel_val;
    idx_t         sel_idx;

    sel4_extreme #(.W(W)) u_sel (
        .a    (elem[0]),
        .b    (elem[1]),
        .c    (elem[2]),
        .d    (elem[3]),
        .mask (mask),
        .val  (sel_val),
        .idx  (sel_idx)
    );

    assign bus.in_ready  = (state == ST_IDLE) && !bus.clr;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

    // clr outranks every handshake, so it is decoded ahead of the state case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mask        <= '0;
            for (int i = 0; i < N; i++) elem[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (bus.clr) begin
            state       <= ST_IDLE;
            mask        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        elem[0] <= bus.in_a;
                        elem[1] <= bus.in_b;
                        elem[2] <= bus.in_c;
                        elem[3] <= bus.in_d;
                        mask    <= 4'b1111;
                        state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    out_data_q  <= sel_val;
                    out_idx_q   <= sel_idx;
                    out_last_q  <= (popcount4(mask) == 3'd1);
                    out_valid_q <= 1'b1;
                    state       <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        mask[out_idx_q] <= 1'b0;
                        out_valid_q     <= 1'b0;
                        state           <= out_last_q ? ST_IDLE : ST_SELECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_sequencer.sv
// Directed bench for sort4_sequencer: table of batches with hand-sorted
// expectations plus backpressure, async reset and clr sequences.
module tb_sort4_sequencer;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    sort4_if #(.W(16)) bus ();

    sort4_sequencer #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][15:0] din;
        logic [3:0][15:0] dout;
        logic [3:0][1:0]  idx;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [15:0] a, b, c, d,
                                input logic [15:0] e0, e1, e2, e3,
                                input logic [1:0] i0, i1, i2, i3);
        vec_t v;
        v.din  = {d, c, b, a};
        v.dout = {e3, e2, e1, e0};
        v.idx  = {i3, i2, i1, i0};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int v);
        bus.in_a     = vecs[v].din[0];
        bus.in_b     = vecs[v].din[1];
        bus.in_c     = vecs[v].din[2];
        bus.in_d     = vecs[v].din[3];
        bus.in_valid = 1'b1;
    endtask

    task automatic run_batch(input int v);
        present(v);
        bus.out_ready = 1'b1;
        chk($sformatf("v%0d in_ready", v), 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk($sformatf("v%0d busy", v), 32'(bus.busy), 32'd1);
        chk($sformatf("v%0d early_valid", v), 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("v%0d e%0d valid", v, k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d e%0d data", v, k), 32'(bus.out_data), 32'(vecs[v].dout[k]));
            chk($sformatf("v%0d e%0d idx", v, k), 32'(bus.out_idx), 32'(vecs[v].idx[k]));
            chk($sformatf("v%0d e%0d last", v, k), 32'(bus.out_last), (k == 3) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("v%0d e%0d drop", v, k), 32'(bus.out_valid), 32'd0);
        end
        chk($sformatf("v%0d done_busy", v), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d done_ready", v), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
`ifdef SORT4_ASCEND_EN
        vecs[0] = mk(3, 9, 1, 7, 1, 3, 7, 9, 2, 0, 3, 1);
        vecs[1] = mk(5, 5, 5, 5, 5, 5, 5, 5, 0, 1, 2, 3);
        vecs[2] = mk(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF,
                     16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 1, 3, 2, 0);
        vecs[3] = mk(1, 2, 3, 4, 1, 2, 3, 4, 0, 1, 2, 3);
        vecs[4] = mk(7, 3, 7, 0, 0, 3, 7, 7, 3, 1, 0, 2);
        vecs[5] = mk(16'h1234, 16'h1234, 16'h0001, 16'hFFFE,
                     16'h0001, 16'h1234, 16'h1234, 16'hFFFE, 2, 0, 1, 3);
`else
        vecs[0] = mk(3, 9, 1, 7, 9, 7, 3, 1, 1, 3, 0, 2);
        vecs[1] = mk(5, 5, 5, 5, 5, 5, 5, 5, 0, 1, 2, 3);
        vecs[2] = mk(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF,
                     16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 0, 2, 3, 1);
        vecs[3] = mk(1, 2, 3, 4, 4, 3, 2, 1, 3, 2, 1, 0);
        vecs[4] = mk(7, 3, 7, 0, 7, 7, 3, 0, 0, 2, 1, 3);
        vecs[5] = mk(16'h1234, 16'h1234, 16'h0001, 16'hFFFE,
                     16'hFFFE, 16'h1234, 16'h1234, 16'h0001, 3, 0, 1, 2);
`endif

        rst           = 1'b1;
        bus.clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.in_d      = '0;
        tick();
        tick();
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data", 32'(bus.out_data), 32'd0);
        chk("rst out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst out_last", 32'(bus.out_last), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        for (int v = 0; v < 6; v++) run_batch(v);

        // Backpressure: stall on the first element while a second batch is offered.
        present(0);
        bus.out_ready = 1'b0;
        tick();
        tick();
        bus.in_a = 16'd10; bus.in_b = 16'd20; bus.in_c = 16'd30; bus.in_d = 16'd40;
        bus.in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp%0d valid", s), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d data", s), 32'(bus.out_data), 32'(vecs[0].dout[0]));
            chk($sformatf("bp%0d idx", s), 32'(bus.out_idx), 32'(vecs[0].idx[0]));
            chk($sformatf("bp%0d in_ready", s), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp handshake_drop", 32'(bus.out_valid), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("bp e%0d data", k), 32'(bus.out_data), 32'(vecs[0].dout[k]));
            chk($sformatf("bp e%0d idx", k), 32'(bus.out_idx), 32'(vecs[0].idx[k]));
            tick();
        end
        chk("bp done_busy", 32'(bus.busy), 32'd0);

        // Async reset between edges while in SELECT.
        present(3);
        tick();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst out_data", 32'(bus.out_data), 32'd0);
        chk("arst out_idx", 32'(bus.out_idx), 32'd0);
        chk("arst busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst in_ready", 32'(bus.in_ready), 32'd1);
        for (int s = 0; s < 4; s++) begin
            tick();
            chk($sformatf("arst%0d no_stale", s), 32'(bus.out_valid), 32'd0);
        end

        // clr during the second EMIT, with out_ready also high.
        present(0);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("clr pre_valid", 32'(bus.out_valid), 32'd1);
        chk("clr pre_data", 32'(bus.out_data), 32'(vecs[0].dout[1]));
        bus.clr = 1'b1;
        #1;
        chk("clr in_ready_gated", 32'(bus.in_ready), 32'd0);
        tick();
        bus.clr = 1'b0;
        #1;
        chk("clr out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr out_last", 32'(bus.out_last), 32'd0);
        chk("clr busy", 32'(bus.busy), 32'd0);
        chk("clr in_ready", 32'(bus.in_ready), 32'd1);
        run_batch(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
